// File: rtl/riscv_multi_pkg.sv
// Shared opcodes, funct3 codes, FSM states and sub-word lane helpers for riscv_multi_hs.
// Pure declarations and combinational functions; no state, no latency.
package riscv_multi_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [2:0] {
        ST_BOOT, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM, ST_HALT
    } state_t;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } lanes_t;

    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  a,
                                                 input logic [2:0]  funct3);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   return {{24{b[7]}}, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LBU:  return {24'b0, b};
            F3_LHU:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    // Store data is replicated into every lane; be selects which lanes the memory keeps.
    function automatic lanes_t store_lanes(input logic [31:0] rs2,
                                           input logic [1:0]  a,
                                           input logic [2:0]  funct3);
        lanes_t l;
        case (funct3)
            F3_SB: begin
                l.be    = 4'b0001 << a;
                l.wdata = {4{rs2[7:0]}};
            end
            F3_SH: begin
                l.be    = 4'b0011 << {a[1], 1'b0};
                l.wdata = {2{rs2[15:0]}};
            end
            F3_SW: begin
                l.be    = 4'b1111;
                l.wdata = rs2;
            end
            default: begin
                l.be    = 4'b1111;
                l.wdata = rs2;
            end
        endcase
        return l;
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// Combinational RV32 ALU and branch comparator.
// Zero latency; no handshake.
module riscv_alu
    import riscv_multi_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic [31:0] result,
    output logic        take_branch
);

    logic [4:0] shamt;
    assign shamt = opB[4:0];

    always_comb begin
        result = '0;
        case (funct3)
            3'b000:  result = funct7b5 ? (opA - opB) : (opA + opB);
            3'b001:  result = opA << shamt;
            3'b010:  result = {31'b0, $signed(opA) < $signed(opB)};
            3'b011:  result = {31'b0, opA < opB};
            3'b100:  result = opA ^ opB;
            3'b101:  result = funct7b5 ? 32'($signed(opA) >>> shamt) : (opA >> shamt);
            3'b110:  result = opA | opB;
            default: result = opA & opB;
        endcase
    end

    always_comb begin
        take_branch = 1'b0;
        case (funct3)
            F3_BEQ:  take_branch = (opA == opB);
            F3_BNE:  take_branch = (opA != opB);
            F3_BLT:  take_branch = ($signed(opA) < $signed(opB));
            F3_BGE:  take_branch = ($signed(opA) >= $signed(opB));
            F3_BLTU: take_branch = (opA < opB);
            F3_BGEU: take_branch = (opA >= opB);
            default: take_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/riscv_multi_hs.sv
// Multicycle RV32I/RV32E core on one shared req/rdy memory port; optional RISCV_MULTI_MISALIGN_TRAP_EN.
// Latency: 3 clk ALU/branch/jump, 4 clk load/store, +1 clk per memory wait cycle.
// Backpressure: FETCH and MEM hold address and request stable until mem_rdy.
module riscv_multi_hs
    import riscv_multi_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rdy,
    input  logic [31:0] mem_rdata,
    output logic        halted,
    output logic        fault
);

    localparam int         IDX_W     = $clog2(REG_COUNT);
    localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

    state_t      state, stateNext;
    logic [31:0] pc, pcNext, instr, rs1Val, rs2Val;
    logic [31:0] regs [1:REG_COUNT-1];

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1Idx, rs2Idx;
    logic [2:0]  funct3;
    logic [31:0] immI, immS, immB, immU, immJ;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1Idx = instr[19:15];
    assign rs2Idx = instr[24:20];
    assign immI   = {{20{instr[31]}}, instr[31:20]};
    assign immS   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign immB   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign immU   = {instr[31:12], 12'b0};
    assign immJ   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    function automatic logic [31:0] readReg(input logic [4:0] idx);
        if (idx == 5'd0 || {1'b0, idx} >= REG_LIMIT)
            return '0;
        return regs[idx[IDX_W-1:0]];
    endfunction

    logic [31:0] aluB, aluResult;
    logic        aluAlt, takeBranch;

    always_comb begin
        aluB   = rs2Val;
        aluAlt = 1'b0;
        case (opcode)
            OP_REG: aluAlt = instr[30];
            OP_IMM: begin
                aluB   = immI;
                aluAlt = instr[30] & (funct3 == 3'b101);
            end
            default: ;
        endcase
    end

    riscv_alu u_alu (
        .funct3      (funct3),
        .funct7b5    (aluAlt),
        .opA         (rs1Val),
        .opB         (aluB),
        .result      (aluResult),
        .take_branch (takeBranch)
    );

    // Halfword/word accesses are forced onto their natural boundary.
    logic [31:0] effAddr, dataAddr;
    lanes_t      lanes;

    assign effAddr = rs1Val + ((opcode == OP_STORE) ? immS : immI);

    always_comb begin
        dataAddr = effAddr;
        if (funct3[1:0] == F3_LH[1:0])
            dataAddr = {effAddr[31:1], 1'b0};
        else if (funct3[1:0] == F3_LW[1:0])
            dataAddr = {effAddr[31:2], 2'b00};
    end

    assign lanes = store_lanes(rs2Val, dataAddr[1:0], funct3);

`ifdef RISCV_MULTI_MISALIGN_TRAP_EN
    logic misaligned, faultSet, faultQ;
    assign misaligned = ((funct3[1:0] == F3_LH[1:0]) & effAddr[0]) |
                        ((funct3[1:0] == F3_LW[1:0]) & (effAddr[1:0] != 2'b00));
`endif

    logic        wbEn;
    logic [31:0] wbData;

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        wbEn      = 1'b0;
        wbData    = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        mem_addr  = pc;
`ifdef RISCV_MULTI_MISALIGN_TRAP_EN
        faultSet  = 1'b0;
`endif
        case (state)
            ST_BOOT: stateNext = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                mem_be  = 4'b1111;
                if (mem_rdy)
                    stateNext = ST_DECODE;
            end
            ST_DECODE: stateNext = ST_EXECUTE;
            ST_EXECUTE: begin
                stateNext = ST_FETCH;
                pcNext    = pc + 32'd4;
                case (opcode)
                    OP_LUI:   begin wbEn = 1'b1; wbData = immU; end
                    OP_AUIPC: begin wbEn = 1'b1; wbData = pc + immU; end
                    OP_JAL: begin
                        wbEn   = 1'b1;
                        wbData = pc + 32'd4;
                        pcNext = pc + immJ;
                    end
                    OP_JALR: begin
                        wbEn   = 1'b1;
                        wbData = pc + 32'd4;
                        pcNext = (rs1Val + immI) & ~32'd1;
                    end
                    OP_BRANCH: if (takeBranch) pcNext = pc + immB;
                    OP_IMM, OP_REG: begin wbEn = 1'b1; wbData = aluResult; end
                    OP_LOAD, OP_STORE: begin
                        stateNext = ST_MEM;
`ifdef RISCV_MULTI_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            stateNext = ST_HALT;
                            pcNext    = pc;
                            faultSet  = 1'b1;
                        end
`endif
                    end
                    // ECALL/EBREAK only; every other SYSTEM encoding falls through as a NOP.
                    OP_SYSTEM: if (funct3 == 3'b000 && instr[31:21] == 11'd0) begin
                        stateNext = ST_HALT;
                        pcNext    = pc;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_addr = dataAddr;
                if (opcode == OP_STORE) begin
                    mem_we    = 1'b1;
                    mem_be    = lanes.be;
                    mem_wdata = lanes.wdata;
                end else begin
                    mem_be = 4'b1111;
                end
                if (mem_rdy) begin
                    stateNext = ST_FETCH;
                    if (opcode == OP_LOAD) begin
                        wbEn   = 1'b1;
                        wbData = load_extract(mem_rdata, dataAddr[1:0], funct3);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_BOOT;
            pc     <= RESET_PC;
            instr  <= '0;
            rs1Val <= '0;
            rs2Val <= '0;
        end else begin
            state <= stateNext;
            pc    <= pcNext;
            if (state == ST_FETCH && mem_rdy)
                instr <= mem_rdata;
            if (state == ST_DECODE) begin
                rs1Val <= readReg(rs1Idx);
                rs2Val <= readReg(rs2Idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < REG_COUNT; i++)
                regs[i] <= '0;
        end else if (wbEn && rd != 5'd0 && {1'b0, rd} < REG_LIMIT) begin
            regs[rd[IDX_W-1:0]] <= wbData;
        end
    end

`ifdef RISCV_MULTI_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            faultQ <= 1'b0;
        else if (faultSet)
            faultQ <= 1'b1;
    end
    assign fault = faultQ;
`else
    assign fault = 1'b0;
`endif

    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_riscv_multi_hs.sv
// Directed bench for riscv_multi_hs: small programs, a wait-state memory model and an RV32E instance.
`timescale 1ns/1ps
module tb_riscv_multi_hs;
    import riscv_multi_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_req, mem_we, mem_rdy, halted, fault;

    logic [31:0] mem [0:255];
    int          waitN = 0;
    int          pend = 0;
    int          dataReads = 0;
    logic [31:0] wrAddr [$];
    logic [3:0]  wrBe   [$];
    logic [31:0] wrData [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign mem_rdy   = (pend >= waitN);
    assign mem_rdata = mem[mem_addr[9:2]];

    riscv_multi_hs #(.RESET_PC(32'h0), .REG_COUNT(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .halted(halted), .fault(fault)
    );

    // RV32E instance with a fixed four-word program and a zero-wait memory.
    logic [31:0] romE [0:3];
    logic [31:0] addrE, wdataE, rdataE;
    logic [3:0]  beE;
    logic        reqE, weE, haltedE, faultE;
    assign rdataE = romE[addrE[3:2]];

    riscv_multi_hs #(.RESET_PC(32'h0), .REG_COUNT(16)) dutE (
        .clk(clk), .reset_n(reset_n),
        .mem_addr(addrE), .mem_req(reqE), .mem_we(weE), .mem_be(beE),
        .mem_wdata(wdataE), .mem_rdy(1'b1), .mem_rdata(rdataE),
        .halted(haltedE), .fault(faultE)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_REG};
    endfunction

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    // One clock: sample the port at the negedge before the edge, apply memory effects after it.
    task automatic tick();
        logic        sReq, sRdy, sWe;
        logic [31:0] sAddr, sData;
        logic [3:0]  sBe;
        sReq = mem_req; sRdy = mem_rdy; sWe = mem_we;
        sAddr = mem_addr; sData = mem_wdata; sBe = mem_be;
        @(posedge clk);
        @(negedge clk);
        if (sReq && sRdy) begin
            if (sWe) begin
                for (int b = 0; b < 4; b++)
                    if (sBe[b]) mem[sAddr[9:2]][8*b +: 8] = sData[8*b +: 8];
                wrAddr.push_back(sAddr);
                wrBe.push_back(sBe);
                wrData.push_back(sData);
            end else if (sAddr >= 32'h100) begin
                dataReads++;
            end
        end
        pend = (sReq && !sRdy) ? pend + 1 : 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_n = 1'b0;
        waitN = 0;
        pend = 0;
        dataReads = 0;
        wrAddr.delete(); wrBe.delete(); wrData.delete();
        for (int i = 0; i < 256; i++) mem[i] = '0;
        @(negedge clk);
    endtask

    task automatic runUntilHalt(input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        checkVal("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        romE[0] = encI(12'd1, 5'd0, 3'b000, 5'd17, OP_IMM);
        romE[1] = encR(7'h00, 5'd0, 5'd17, 3'b000, 5'd1);
        romE[2] = encI(12'd3, 5'd0, 3'b000, 5'd2, OP_IMM);
        romE[3] = EBREAK;

        // Reset state and the three-instruction halt timing.
        doReset();
        mem[0] = encI(12'd5,   5'd0, 3'b000, 5'd1, OP_IMM);
        mem[1] = encI(12'hFF9, 5'd1, 3'b000, 5'd2, OP_IMM);
        mem[2] = EBREAK;
        checkVal("rst_req",   32'(mem_req), 32'd0);
        checkVal("rst_we",    32'(mem_we), 32'd0);
        checkVal("rst_be",    32'(mem_be), 32'd0);
        checkVal("rst_wdata", mem_wdata, 32'd0);
        checkVal("rst_addr",  mem_addr, 32'd0);
        checkVal("rst_flags", {30'd0, halted, fault}, 32'd0);
        reset_n = 1'b1;
        tick();
        checkVal("fetch0", {mem_req, mem_be, mem_addr[26:0]}, {1'b1, 4'hF, 27'd0});
        repeat (8) tick();
        checkVal("halted_c8", 32'(halted), 32'd0);
        tick();
        checkVal("halted_c9", 32'(halted), 32'd1);
        checkVal("halt_req",  32'(mem_req), 32'd0);
        checkVal("halt_pc",   dut.pc, 32'd8);
        checkVal("addi_x1",   dut.regs[1], 32'd5);
        checkVal("addi_x2",   dut.regs[2], 32'hFFFF_FFFE);
        repeat (5) tick();
        checkVal("halt_stays", {31'd0, halted}, 32'd1);
        checkVal("rv32e_halt", 32'(haltedE), 32'd1);
        checkVal("rv32e_x1",   dutE.regs[1], 32'd0);
        checkVal("rv32e_x2",   dutE.regs[2], 32'd3);

        // Sub-word loads plus a misaligned word load.
        doReset();
        mem[0] = encI(12'h101, 5'd0, F3_LB,  5'd3, OP_LOAD);
        mem[1] = encI(12'h103, 5'd0, F3_LBU, 5'd4, OP_LOAD);
        mem[2] = encI(12'h102, 5'd0, F3_LH,  5'd5, OP_LOAD);
        mem[3] = encI(12'h102, 5'd0, F3_LHU, 5'd6, OP_LOAD);
        mem[4] = encI(12'h100, 5'd0, F3_LW,  5'd7, OP_LOAD);
        mem[5] = encI(12'h100, 5'd0, F3_LB,  5'd8, OP_LOAD);
        mem[6] = encI(12'h102, 5'd0, F3_LW,  5'd9, OP_LOAD);
        mem[7] = EBREAK;
        mem[8'h40] = 32'h8844_22F1;
        reset_n = 1'b1;
        runUntilHalt(200);
        checkVal("lb_x3",  dut.regs[3], 32'h0000_0022);
        checkVal("lbu_x4", dut.regs[4], 32'h0000_0088);
        checkVal("lh_x5",  dut.regs[5], 32'hFFFF_8844);
        checkVal("lhu_x6", dut.regs[6], 32'h0000_8844);
        checkVal("lw_x7",  dut.regs[7], 32'h8844_22F1);
        checkVal("lb_x8",  dut.regs[8], 32'hFFFF_FFF1);
`ifdef RISCV_MULTI_MISALIGN_TRAP_EN
        checkVal("mis_fault", 32'(fault), 32'd1);
        checkVal("mis_x9",    dut.regs[9], 32'd0);
        checkVal("mis_pc",    dut.pc, 32'd24);
        checkVal("mis_reads", 32'(dataReads), 32'd6);
`else
        checkVal("mis_fault", 32'(fault), 32'd0);
        checkVal("mis_x9",    dut.regs[9], 32'h8844_22F1);
        checkVal("mis_pc",    dut.pc, 32'd28);
        checkVal("mis_reads", 32'(dataReads), 32'd7);
`endif

        // Byte and halfword stores with lane steering.
        doReset();
        mem[0] = {20'hAABBD, 5'd6, OP_LUI};
        mem[1] = encI(12'hCDD, 5'd6, 3'b000, 5'd6, OP_IMM);
        mem[2] = encS(12'h202, 5'd6, 5'd0, F3_SB);
        mem[3] = encS(12'h200, 5'd6, 5'd0, F3_SH);
        mem[4] = EBREAK;
        reset_n = 1'b1;
        runUntilHalt(200);
        checkVal("st_x6",    dut.regs[6], 32'hAABB_CCDD);
        checkVal("st_count", 32'(wrAddr.size()), 32'd2);
        if (wrAddr.size() == 2) begin
            checkVal("sb_addr",  wrAddr[0], 32'h202);
            checkVal("sb_be",    32'(wrBe[0]), 32'h4);
            checkVal("sb_wdata", wrData[0], 32'hDDDD_DDDD);
            checkVal("sh_addr",  wrAddr[1], 32'h200);
            checkVal("sh_be",    32'(wrBe[1]), 32'h3);
            checkVal("sh_wdata", wrData[1], 32'hCCDD_CCDD);
        end
        checkVal("st_word", mem[8'h80], 32'h00DD_CCDD);

        // Three wait cycles in both FETCH and MEM of a LW.
        doReset();
        mem[0] = encI(12'h100, 5'd0, F3_LW, 5'd10, OP_LOAD);
        mem[1] = EBREAK;
        mem[8'h40] = 32'h8844_22F1;
        waitN = 3;
        reset_n = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 10; cyc++) begin
            checkVal("wait_req", 32'(mem_req), (cyc == 5 || cyc == 6) ? 32'd0 : 32'd1);
            if (cyc <= 4)
                checkVal("wait_faddr", mem_addr, 32'd0);
            else if (cyc >= 7)
                checkVal("wait_maddr", {mem_we, mem_addr[30:0]}, 32'h100);
            if (cyc == 10)
                checkVal("wait_x10_pre", dut.regs[10], 32'd0);
            tick();
        end
        checkVal("wait_x10", dut.regs[10], 32'h8844_22F1);
        checkVal("wait_next", {mem_req, mem_addr[30:0]}, {1'b1, 31'd4});

        // Branches, jumps, SUB and SRAI.
        doReset();
        mem[0]  = encI(12'hFFD, 5'd0, 3'b000, 5'd1, OP_IMM);
        mem[1]  = encI(12'd4,   5'd0, 3'b000, 5'd2, OP_IMM);
        mem[2]  = encB(13'd8, 5'd2, 5'd1, F3_BLT);
        mem[3]  = encI(12'd99,  5'd0, 3'b000, 5'd3, OP_IMM);
        mem[4]  = encB(13'd8, 5'd2, 5'd1, F3_BLTU);
        mem[5]  = encJ(21'd8, 5'd4);
        mem[6]  = encI(12'd77,  5'd0, 3'b000, 5'd3, OP_IMM);
        mem[7]  = encR(7'h20, 5'd1, 5'd2, 3'b000, 5'd5);
        mem[8]  = encI(12'h401, 5'd1, 3'b101, 5'd6, OP_IMM);
        mem[9]  = encI(12'd45,  5'd0, 3'b000, 5'd7, OP_JALR);
        mem[10] = encI(12'd55,  5'd0, 3'b000, 5'd3, OP_IMM);
        mem[11] = EBREAK;
        reset_n = 1'b1;
        runUntilHalt(200);
        checkVal("br_x3",   dut.regs[3], 32'd0);
        checkVal("jal_x4",  dut.regs[4], 32'd24);
        checkVal("sub_x5",  dut.regs[5], 32'd7);
        checkVal("srai_x6", dut.regs[6], 32'hFFFF_FFFE);
        checkVal("jalr_x7", dut.regs[7], 32'd40);
        checkVal("br_pc",   dut.pc, 32'd44);

        // Reset asserted while a load waits in MEM.
        doReset();
        mem[0] = encI(12'h100, 5'd0, F3_LW, 5'd10, OP_LOAD);
        mem[1] = EBREAK;
        waitN = 3;
        reset_n = 1'b1;
        repeat (7) tick();
        checkVal("mid_req_pre", {mem_req, mem_addr[30:0]}, {1'b1, 31'h100});
        reset_n = 1'b0;
        #1;
        checkVal("mid_req_drop", 32'(mem_req), 32'd0);
        checkVal("mid_addr",     mem_addr, 32'd0);
        checkVal("mid_x10",      dut.regs[10], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
